// File: rtl/mag_cmp_pkg.sv
// Shared constants for the serial magnitude comparator family.
// State encodings are fixed so existing comparator benches can decode them.
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a bit index able to address every operand bit (at least 1 bit).
  function automatic int idx_bits(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_cmp_1b.sv
// Single-bit magnitude decision. At the sign bit of a two's complement
// operand a set A bit means A is the smaller value, so the sense flips.
module bit_cmp_1b (
  input  logic a_bit,
  input  logic b_bit,
  input  logic msb,
  input  logic signed_mode,
  output logic gt_bit,
  output logic lt_bit
);

  logic diff;
  logic inv;

  always_comb begin
    diff   = a_bit ^ b_bit;
    inv    = msb & signed_mode;
    gt_bit = diff & (a_bit ^ inv);
    lt_bit = diff & (b_bit ^ inv);
  end

endmodule

// File: rtl/mag_cmp_serial.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// Operands are captured on accept so the inputs may change during a scan.
//
// state | meaning
// IDLE  | waiting for start, last result held
// CMP   | scanning one bit per cycle, busy=1
// DONE  | result valid, done=1 for this single cycle
import mag_cmp_pkg::*;

module mag_cmp_serial #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int            IW      = idx_bits(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic accept;
  logic a_bit, b_bit, msb;
  logic bit_gt, bit_lt;
  logic decided, last_bit, finish;

  always_comb begin
    accept   = start && (state_q != CMP);
    a_bit    = a_q[idx_q];
    b_bit    = b_q[idx_q];
    msb      = (idx_q == IDX_MSB);
    decided  = gt_q | lt_q;
    last_bit = (idx_q == '0);
    finish   = (EARLY_EXIT && (bit_gt || bit_lt)) || last_bit;
  end

  bit_cmp_1b u_bit_cmp (
    .a_bit       (a_bit),
    .b_bit       (b_bit),
    .msb         (msb),
    .signed_mode (sm_q),
    .gt_bit      (bit_gt),
    .lt_bit      (bit_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CMP;
      CMP:     if (finish) state_d = DONE;
      DONE:    state_d = start ? CMP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    a_d   = a_q;
    b_d   = b_q;
    sm_d  = sm_q;
    gt_d  = gt_q;
    lt_d  = lt_q;
    eq_d  = eq_q;
    if (accept) begin
      idx_d = IDX_MSB;
      a_d   = a;
      b_d   = b;
      sm_d  = signed_mode;
      gt_d  = 1'b0;
      lt_d  = 1'b0;
      eq_d  = 1'b0;
    end else if (state_q == CMP) begin
      // Only the first differing bit decides; later bits never overwrite it.
      if (!decided) begin
        gt_d = bit_gt;
        lt_d = bit_lt;
      end
      if (last_bit && !decided && !bit_gt && !bit_lt) begin
        eq_d = 1'b1;
      end
      if (!finish) begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= IDX_MSB;
      a_q   <= '0;
      b_q   <= '0;
      sm_q  <= 1'b0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sm_q  <= sm_d;
      gt_q  <= gt_d;
      lt_q  <= lt_d;
      eq_q  <= eq_d;
    end
  end

  always_comb begin
    busy = (state_q == CMP);
    done = (state_q == DONE);
    gt   = gt_q;
    lt   = lt_q;
    eq   = eq_q;
  end

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Scoreboard bench for mag_cmp_serial: one early-exit and one full-scan
// instance share stimulus; expected flags, latency and busy length are queued.
module tb_mag_cmp_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sm;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic busy1, done1, gt1, lt1, eq1;
  logic busy0, done0, gt0, lt0, eq0;

  typedef struct {
    logic gt;
    logic lt;
    logic eq;
    int   cyc;
    int   k;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   bcnt1   = 0;
  int   bcnt0   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mag_cmp_serial #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy1), .done(done1), .gt(gt1), .lt(lt1), .eq(eq1)
  );

  mag_cmp_serial #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_ee0 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy0), .done(done0), .gt(gt0), .lt(lt0), .eq(eq0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge just before the accepting edge.
  task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsm);
    exp_t e;
    int   k1;
    bit   found;
    k1    = W;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && (ta[i] != tb_[i])) begin
        k1    = W - i;
        found = 1'b1;
      end
    end
    e.gt  = tsm ? ($signed(ta) > $signed(tb_)) : (ta > tb_);
    e.lt  = tsm ? ($signed(ta) < $signed(tb_)) : (ta < tb_);
    e.eq  = (ta == tb_);
    e.cyc = cyc + 1 + k1;
    e.k   = k1;
    q1.push_back(e);
    e.cyc = cyc + 1 + W;
    e.k   = W;
    q0.push_back(e);
  endtask

  // Assumes the caller sits on a negedge; returns on the following negedge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsm,
                        input bit expect_accept);
    a     = ta;
    b     = tb_;
    sm    = tsm;
    start = 1'b1;
    if (expect_accept) push_exp(ta, tb_, tsm);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scrambles operands while results are pending; they were captured on accept.
  task automatic wait_idle();
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 40) begin
      @(negedge clk);
      #1;
      a  = W'($urandom);
      b  = W'($urandom);
      sm = 1'($urandom);
      n++;
    end
    chk("pending_results", q1.size() + q0.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (busy1) bcnt1++;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("ee1_spurious_done", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("ee1_gt", gt1, e.gt);
        chk("ee1_lt", lt1, e.lt);
        chk("ee1_eq", eq1, e.eq);
        chk("ee1_latency", cyc, e.cyc);
        chk("ee1_busy_cycles", bcnt1, e.k);
      end
      bcnt1 = 0;
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (busy0) bcnt0++;
    if (done0) begin
      if (q0.size() == 0) begin
        chk("ee0_spurious_done", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("ee0_gt", gt0, e.gt);
        chk("ee0_lt", lt0, e.lt);
        chk("ee0_eq", eq0, e.eq);
        chk("ee0_latency", cyc, e.cyc);
        chk("ee0_busy_cycles", bcnt0, e.k);
      end
      bcnt0 = 0;
    end
  end

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_flags1"}, {gt1, lt1, eq1}, 0);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_flags0"}, {gt0, lt0, eq0}, 0);
  endtask

  initial begin : stim
    int c0;
    rst   = 1'b1;
    start = 1'b0;
    sm    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    launch(8'h00, 8'h00, 1'b0, 1'b1); wait_idle();
    launch(8'h80, 8'h7F, 1'b0, 1'b1); wait_idle();
    launch(8'h80, 8'h7F, 1'b1, 1'b1); wait_idle();
    launch(8'h05, 8'h04, 1'b0, 1'b1); wait_idle();
    launch(8'h40, 8'h00, 1'b0, 1'b1); wait_idle();
    launch(8'hFF, 8'h01, 1'b1, 1'b1); wait_idle();

    // A start two cycles into a scan must be dropped.
    launch(8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    launch(8'hFF, 8'h00, 1'b0, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("hold_lt1", {gt1, lt1, eq1}, 3'b010);
    chk("hold_lt0", {gt0, lt0, eq0}, 3'b010);

    // Reset three cycles into a scan aborts it silently.
    launch(8'h33, 8'h33, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("abort");
    q1.delete();
    q0.delete();
    bcnt1 = 0;
    bcnt0 = 0;
    repeat (10) @(negedge clk);
    launch(8'hFE, 8'hFE, 1'b0, 1'b1); wait_idle();

    // New start presented during DONE must chain without an idle cycle.
    c0 = cyc;
    launch(8'h5A, 8'h5A, 1'b0, 1'b1);
    while (cyc < c0 + 1 + W) @(negedge clk);
    chk("b2b_done1", done1, 1);
    chk("b2b_done0", done0, 1);
    launch(8'h01, 8'h02, 1'b1, 1'b1);
    chk("b2b_busy1", busy1, 1);
    chk("b2b_busy0", busy0, 1);
    wait_idle();

    repeat (12) begin
      launch(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
